stream_rr_arbiter: RTL and testbench
====================================

// Module: stream_rr_arbiter
// PURPOSE
//   Shares one 8-bit valid/ready consumer channel among N_REQ producers.
//   - Grant scheme: round-robin, with bounded bursts per grant.
//   - Output: a one-entry registered stage driving the consumer side.
//   - Placement: between multiple producer modports and a single consumer modport.
//   - Guarantees per-beat handshake integrity and starvation-free access.
// PARAMETERS
//   N_REQ      4   number of requesting producers (>=2)
//   DATA_W     8   payload width per beat
//   MAX_BURST  4   max beats accepted per grant before rotating (>=1)
// PORTS
//   clk        in   1               single clock; all logic on posedge
//   rst_n      in   1               asynchronous, active-low reset
//   req_valid  in   N_REQ           per-producer beat valid
//   req_data   in   N_REQ*DATA_W    per-producer payload; slice i = [i*DATA_W +: DATA_W]
//   req_ready  out  N_REQ           per-producer accept; at most one bit high
//   out_valid  out  1               registered beat valid to consumer
//   out_data   out  DATA_W          registered payload to consumer
//   out_ready  in   1               consumer accept
//   grant_id   out  $clog2(N_REQ)   index of current/last granted producer
//   busy       out  1               high in GRANT or while out_valid
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, rr_ptr=0, beat_cnt=0, out_valid=0,
//     out_data=0, grant_id=0, req_ready=0. Any buffered beat is discarded.
//     Reset asserted mid-burst aborts the burst; no beat is emitted.
//   slot_free = !out_valid || out_ready.
//   FSM states: IDLE, GRANT.
//   IDLE:
//     - req_ready=0.
//     - If any req_valid: grant_id <= first i with req_valid[i], searching
//       rr_ptr, rr_ptr+1, ... mod N_REQ.
//     - Then beat_cnt <= 0 and go to GRANT (1-cycle arbitration bubble).
//   GRANT:
//     - req_ready[grant_id] = slot_free, combinational; all other req_ready bits are 0.
//     - Accept = req_valid[grant_id] && req_ready[grant_id].
//       On accept: out_data <= slice, out_valid <= 1, beat_cnt++.
//     - Exit to IDLE with rr_ptr <= (grant_id+1) mod N_REQ (wrap N_REQ-1 -> 0) when:
//       (a) accept && beat_cnt==MAX_BURST-1, or
//       (b) slot_free && !req_valid[grant_id] (producer idle).
//   Output stage:
//     - Latency is one cycle from accept to out_valid.
//     - out_valid&&out_ready with no new accept: out_valid <= 0.
//     - Simultaneous drain and accept: out_valid stays 1 with the new data,
//       giving full throughput.
//     - While out_valid && !out_ready: out_data is held stable and
//       req_ready is all-zero (backpressure).
//   Requester lifecycle:
//     - A requester that raises valid while not granted waits; it is
//       served within N_REQ-1 grants (no starvation).
//     - Dropping req_valid while not granted has no effect.
//   busy = (state==GRANT) || out_valid.
//   Any beat offered is either accepted exactly once or not at all;
//   no duplication, no reordering within a requester.
// TESTING
//   1 Reset: rst_n=0 with out_valid=1 mid-burst -> all outputs 0 the same cycle, state IDLE.
//   2 Single requester: req0 sends 0x11,0x22,0x33 with out_ready=1 -> out_data 0x11,0x22,0x33
//     on consecutive cycles, each 1 cycle after accept; grant_id=0.
//   3 Round-robin: req0..3 all valid continuously, MAX_BURST=4 -> grants 0,1,2,3,0; 4 beats each;
//     one idle bubble per rotation.
//   4 Backpressure: out_ready=0 for 5 cycles while out_data=0xA5 -> out_data stable,
//     req_ready=0; on release 0xA5 drains, next beat follows.
//   5 Early release: req2 granted, drops valid after 1 beat -> rr_ptr=3, next grant to req3 if valid,
//     else wraps to req0.
//   6 Sparse: only req3 valid, rr_ptr=0 -> grant_id=3, then rr_ptr wraps to 0.

Source files
------------

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter that shares one valid/ready consumer channel among N_REQ
// producers. Each grant is limited to MAX_BURST beats. Accepted beats pass
// through a one-entry registered output stage.
module stream_rr_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy
);

  localparam int unsigned IdW  = $clog2(N_REQ);
  localparam int unsigned CntW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e             state_q;
  logic [IdW-1:0]     rr_ptr_q;
  logic [IdW-1:0]     grant_id_q;
  logic [CntW-1:0]    beat_cnt_q;
  logic               out_valid_q;
  logic [DATA_W-1:0]  out_data_q;

  logic [IdW-1:0]     arb_idx;
  logic [IdW-1:0]     next_ptr;
  logic               any_req;
  logic               slot_free;
  logic               grant_valid;
  logic               accept;
  logic               burst_done;
  logic               grant_end;

  // Pick the first valid requester, searching upward from rr_ptr with wrap-around.
  always_comb begin
    logic found;
    found   = 1'b0;
    arb_idx = rr_ptr_q;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      int unsigned idx;
      idx = 32'(rr_ptr_q) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[idx[IdW-1:0]]) begin
        found   = 1'b1;
        arb_idx = idx[IdW-1:0];
      end
    end
  end

  // Handshake and grant-exit decode.
  always_comb begin
    any_req     = |req_valid;
    slot_free   = !out_valid_q || out_ready;
    grant_valid = req_valid[grant_id_q];
    accept      = (state_q == StGrant) && grant_valid && slot_free;
    burst_done  = accept && (beat_cnt_q == CntW'(MAX_BURST - 1));
    // Rotate when the burst is used up or when the owner has nothing to send.
    grant_end   = (state_q == StGrant) && (burst_done || (slot_free && !grant_valid));
    next_ptr    = (grant_id_q == IdW'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
  end

  // Only the granted producer can see ready, and only when the output slot can take a beat.
  always_comb begin
    req_ready = '0;
    if (state_q == StGrant) req_ready[grant_id_q] = slot_free;
  end

  // Arbitration FSM plus the registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            grant_id_q <= arb_idx;
            beat_cnt_q <= '0;
            state_q    <= StGrant;
          end
        end
        StGrant: begin
          if (accept) beat_cnt_q <= beat_cnt_q + 1'b1;
          if (grant_end) begin
            rr_ptr_q <= next_ptr;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // A drain and a new accept in the same cycle keep out_valid high.
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= req_data[grant_id_q*DATA_W +: DATA_W];
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q == StGrant) || out_valid_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed scoreboard bench for stream_rr_arbiter (N_REQ=4, DATA_W=8, MAX_BURST=4).
module tb_stream_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [1:0]     grant_id;
  logic           busy;

  stream_rr_arbiter #(
    .N_REQ     (N),
    .DATA_W    (W),
    .MAX_BURST (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Producer sources and scoreboard queues.
  logic [W-1:0] src_data [N][32];
  int           head [N];
  int           tail [N];
  logic [W-1:0] exp_q [$];
  int           exp_gnt [$];
  int           checks = 0;
  int           errors = 0;
  logic         pend_lat;
  logic [W-1:0] lat_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic load(input int i, input logic [W-1:0] d);
    src_data[i][tail[i]] = d;
    tail[i]++;
  endtask

  task automatic expect_beat(input int i, input logic [W-1:0] d);
    exp_q.push_back(d);
    exp_gnt.push_back(i);
  endtask

  task automatic clear_tb();
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    exp_q.delete();
    exp_gnt.delete();
    pend_lat = 1'b0;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (head[i] < tail[i]) begin
        req_valid[i]       = 1'b1;
        req_data[i*W +: W] = src_data[i][head[i]];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*W +: W] = '0;
      end
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += tail[i] - head[i];
    return s;
  endfunction

  // One clock: observe at negedge, advance producers just after posedge.
  task automatic cycle();
    int           acc;
    logic [W-1:0] acc_data;
    @(negedge clk);
    if (pend_lat) begin
      check("latency_valid", 32'(out_valid), 1);
      check("latency_data", 32'(out_data), 32'(lat_data));
    end
    pend_lat = 1'b0;
    check("ready_onehot", 32'($countones(req_ready) <= 1), 1);
    acc = -1;
    acc_data = '0;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        acc      = i;
        acc_data = req_data[i*W +: W];
      end
    end
    if (acc >= 0) begin
      if (exp_gnt.size() == 0) check("unexpected_accept", 32'(acc), 32'hFFFF);
      else check("grant_order", 32'(acc), 32'(exp_gnt.pop_front()));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", 32'(out_data), 32'hFFFF);
      else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
    if (acc >= 0) begin
      head[acc]++;
      pend_lat = 1'b1;
      lat_data = acc_data;
    end
    drive_inputs();
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() > 0 || busy) && n < 60) begin
      cycle();
      n++;
    end
    check("drain_timeout", 32'(n < 60), 1);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    out_ready = 1'b0;
    req_valid = '0;
    req_data  = '0;
    clear_tb();
    repeat (2) @(posedge clk);
    #1;
    // Reset values
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single requester streaming three beats
    out_ready = 1'b1;
    load(0, 8'h11); load(0, 8'h22); load(0, 8'h33);
    expect_beat(0, 8'h11); expect_beat(0, 8'h22); expect_beat(0, 8'h33);
    drive_inputs();
    cycle();
    check("single_grant_id", 32'(grant_id), 0);
    check("single_busy", 32'(busy), 1);
    drain();
    check("single_idle_busy", 32'(busy), 0);

    // Asynchronous reset mid-burst with a beat held in the output stage
    out_ready = 1'b0;
    load(1, 8'hC1); load(1, 8'hC2); load(1, 8'hC3);
    expect_beat(1, 8'hC1);
    drive_inputs();
    cycle();
    cycle();
    check("pre_rst_out_valid", 32'(out_valid), 1);
    check("pre_rst_grant_id", 32'(grant_id), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 0);
    check("async_rst_out_data", 32'(out_data), 0);
    check("async_rst_req_ready", 32'(req_ready), 0);
    check("async_rst_grant_id", 32'(grant_id), 0);
    check("async_rst_busy", 32'(busy), 0);
    clear_tb();
    drive_inputs();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("post_rst_out_valid", 32'(out_valid), 0);

    // Sparse: only requester 3 with rr_ptr at 0
    load(3, 8'hD0); load(3, 8'hD1);
    expect_beat(3, 8'hD0); expect_beat(3, 8'hD1);
    drive_inputs();
    cycle();
    check("sparse_grant_id", 32'(grant_id), 3);
    drain();
    check("sparse_hold_grant_id", 32'(grant_id), 3);
    check("sparse_busy", 32'(busy), 0);

    // Round-robin with all requesters busy: 0,1,2,3,0 with four-beat bursts
    for (int b = 0; b < 8; b++) load(0, 8'(b));
    for (int i = 1; i < N; i++)
      for (int b = 0; b < 4; b++) load(i, 8'(i * 16 + b));
    for (int i = 0; i < N; i++)
      for (int b = 0; b < 4; b++) expect_beat(i, 8'(i * 16 + b));
    for (int b = 4; b < 8; b++) expect_beat(0, 8'(b));
    drive_inputs();
    n = 0;
    while (pending() > 0 && n < 100) begin
      cycle();
      n++;
    end
    // 5 grants, each one arbitration bubble plus four beats
    check("rr_cycle_count", 32'(n), 25);
    drain();
    check("rr_busy", 32'(busy), 0);

    // Backpressure: 0xA5 held for five cycles
    out_ready = 1'b0;
    load(0, 8'hA5); load(0, 8'hB6);
    expect_beat(0, 8'hA5); expect_beat(0, 8'hB6);
    drive_inputs();
    cycle();
    cycle();
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_out_data", 32'(out_data), 32'h0A5);
      check("bp_req_ready", 32'(req_ready), 0);
    end
    out_ready = 1'b1;
    drain();

    // Early release of requester 2; requester 3 is next, then wrap to 0
    load(2, 8'h52); load(3, 8'h53); load(0, 8'h50);
    expect_beat(2, 8'h52); expect_beat(3, 8'h53); expect_beat(0, 8'h50);
    drive_inputs();
    drain();

    // Early release of requester 2 with requester 3 idle: wraps to 0
    load(2, 8'h62); load(0, 8'h60);
    expect_beat(2, 8'h62); expect_beat(0, 8'h60);
    drive_inputs();
    drain();
    check("final_grant_id", 32'(grant_id), 0);
    check("final_scoreboard_empty", 32'(exp_q.size() + exp_gnt.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
